// File: rtl/bc_input_port.sv
// Serial 8N1 receiver feeding the Basic Computer input register (INPR) and flag (FGI).
// Detects frame errors and overruns; the controller clears FGI with inp_ack.
//
//   state   | meaning
//   IDLE    | line idle, waiting for a falling edge on the synchronized line
//   START   | counting half a bit, then confirming the start bit
//   DATA    | sampling DATA_W bits at bit centres, LSB first
//   STOP    | waiting for the stop-bit sample; accept or flag a frame error
//   RECOVER | line held low after a bad stop bit; wait for idle-high
module bc_input_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              inp_ack,
  input  logic              err_clr,
  output logic [DATA_W-1:0] INPR,
  output logic              FGI,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              rx_s1, rs;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [BW-1:0]     bit_idx, bit_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              stop_good, stop_bad, tc;
  logic              load, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rs    <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  assign tc = (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rs) begin
          state_nxt = START;
          cnt_nxt   = HALF_TC;
        end
      end
      START: begin
        if (tc) begin
          if (rs) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = BIT_TC;
            bit_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (tc) begin
          shift_nxt = {rs, shift[DATA_W-1:1]};
          cnt_nxt   = BIT_TC;
          bit_nxt   = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (tc) begin
          if (rs) begin
            stop_good = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = RECOVER;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (rs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A coincident inp_ack frees INPR in the same cycle, so the new byte is taken.
  assign load = stop_good && (!FGI || inp_ack);
  assign drop = stop_good && FGI && !inp_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      INPR      <= '0;
      FGI       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        INPR <= shift;
        FGI  <= 1'b1;
      end else if (inp_ack) begin
        FGI <= 1'b0;
      end

      if (stop_bad)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;

      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bc_input_port.sv
// Directed bench for bc_input_port: serial frames driven bit by bit, expected
// bytes queued on send and popped when the DUT presents a new byte.
module tb_bc_input_port;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       inp_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] INPR;
  logic       FGI;
  logic       frame_err;
  logic       overrun;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         rise;

  bc_input_port #(.CLKS_PER_BIT(N), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .inp_ack  (inp_ack),
    .err_clr  (err_clr),
    .INPR     (INPR),
    .FGI      (FGI),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 inp_ack = 1'b1;
    @(posedge clk); #1 inp_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] e_inpr, input logic e_fgi,
                               input logic e_ferr, input logic e_ovr);
    check({tag, "_inpr"}, INPR, e_inpr);
    check({tag, "_fgi"}, FGI, e_fgi);
    check({tag, "_frame_err"}, frame_err, e_ferr);
    check({tag, "_overrun"}, overrun, e_ovr);
  endtask

  // Cycle c counts posedges after the start bit is driven; inputs change #1 after each edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_cyc,
                            input int abort_cyc, output int rise_cyc);
    logic [9:0] fr;
    logic [7:0] prev_inpr;
    logic       prev_fgi;
    logic [7:0] e;
    fr = {stop, d, 1'b0};
    rise_cyc = -1;
    @(posedge clk); #1;
    rx = fr[0];
    prev_inpr = INPR;
    prev_fgi = FGI;
    for (int c = 1; c <= 10 * N; c++) begin
      @(posedge clk); #1;
      if (c == abort_cyc) begin
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check_outputs("abort", 8'h00, 1'b0, 1'b0, 1'b0);
        return;
      end
      if ((FGI && !prev_fgi) || (INPR !== prev_inpr)) begin
        if (rise_cyc < 0) rise_cyc = c;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", 32'(INPR), 32'h100);
        end else begin
          e = exp_q.pop_front();
          check("sb_inpr", INPR, e);
          check("sb_fgi", FGI, 1'b1);
        end
      end
      prev_inpr = INPR;
      prev_fgi = FGI;
      inp_ack = (c == ack_cyc);
      rx = (c < 10 * N) ? fr[4'(c / N)] : 1'b1;
    end
    inp_ack = 1'b0;
    rx = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cycles(3);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycles(500);
    check_outputs("idle500", 8'h00, 1'b0, 1'b0, 1'b0);

    // Start bit driven before edge 1; t0 is edge 3 after the synchronizer, so FGI rises at edge 155.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, rise);
    check("a5_rise_cycle", rise, 155);
    check_outputs("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    pulse_ack();
    check_outputs("a5_ack", 8'hA5, 1'b0, 1'b0, 1'b0);

    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, rise);
    check("a5_again_seen", rise >= 0, 1'b1);
    send_frame(8'h3C, 1'b1, -1, -1, rise);
    check_outputs("overrun", 8'hA5, 1'b1, 1'b0, 1'b1);
    pulse_clr();
    check_outputs("overrun_clr", 8'hA5, 1'b1, 1'b0, 1'b0);

    send_frame(8'h5A, 1'b0, -1, -1, rise);
    check_outputs("frame_err", 8'hA5, 1'b1, 1'b1, 1'b0);
    cycles(20);
    pulse_clr();
    check("frame_err_clr", frame_err, 1'b0);
    pulse_ack();
    check("fgi_clear_before_11", FGI, 1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, rise);
    check_outputs("after_err_11", 8'h11, 1'b1, 1'b0, 1'b0);

    pulse_ack();
    @(posedge clk); #1 rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(40);
    check_outputs("glitch", 8'h11, 1'b0, 1'b0, 1'b0);

    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, -1, -1, rise);
    check_outputs("pre_ack_race", 8'h22, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 154, -1, rise);
    check("ack_race_event_cycle", rise, 155);
    check_outputs("ack_race", 8'h99, 1'b1, 1'b0, 1'b0);

    send_frame(8'h77, 1'b1, -1, 60, rise);
    cycles(3);
    check_outputs("in_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycles(5);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, -1, -1, rise);
    check("ff_rise_cycle", rise, 155);
    check_outputs("after_reset_ff", 8'hFF, 1'b1, 1'b0, 1'b0);

    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
